cnt_pair_sched: RTL
===================

Name: cnt_pair_sched

Overview:
- Run controller for the two-counter datapath: two cnt_10bits instances, the cmp_eq comparator and the carry-race fsm.
- Latches a modulus pair on request and holds both counters in reset while loading.
- Releases the counters together for a programmable window of CLK cycles, tallying CoutA, CoutB and cntA_EQ_cntB hits.
- Reports a verdict at window end. Sits beside lab_MS_SV1-style top levels and drives cntA_Module, cntB_Module and the counters' rst_n.

Parameters:
WIN_W, 16, width of the window-length input (max window 2^WIN_W-1 cycles)
TALLY_W, 12, width of each saturating tally

Ports:
CLK  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
abort  input  1  terminates an active run (LOAD or RUN)
cfg_modA  input  10  modulus for counter A, latched on accepted start
cfg_modB  input  10  modulus for counter B, latched on accepted start
cfg_win  input  WIN_W  run length in cycles, latched on accepted start
CoutA  input  1  carry pulse from counter A
CoutB  input  1  carry pulse from counter B
cntA_EQ_cntB  input  1  comparator output
cntA_Module  output  10  modulus driven to counter A
cntB_Module  output  10  modulus driven to counter B
cnt_rst_n  output  1  active-low reset to both counters and the fsm
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse at end of a completed or rejected run
err  output  1  last run rejected (bad config); valid from done until next accepted start
tallyA  output  TALLY_W  CoutA pulses counted in last run
tallyB  output  TALLY_W  CoutB pulses counted in last run
eq_hits  output  TALLY_W  cycles with cntA_EQ_cntB=1 in last run
verdict  output  2  00 equal, 01 A>B, 10 B>A, 11 unused; compares tallyA against tallyB

Behaviour:
- Clock and reset: one clock, CLK. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; cntA_Module=cntB_Module=0; cnt_rst_n=0; busy=0; done=0; err=0; tallies=0; verdict=00; window counter=0.
- States: IDLE, LOAD, RUN, REPORT.
- IDLE:
  - cnt_rst_n=0.
  - When start=1, latch cfg_modA, cfg_modB and cfg_win.
  - If any latched field is 0: set err=1, go to REPORT. No counter release; tallies cleared to 0.
  - Otherwise: clear tallies and err, go to LOAD.
- LOAD (exactly 1 cycle):
  - Module outputs show the latched values; cnt_rst_n=0, so the counters see a stable modulus while in reset.
  - Load window counter = cfg_win. Go to RUN.
- RUN:
  - cnt_rst_n=1.
  - Each cycle: tallyA += CoutA, tallyB += CoutB, eq_hits += cntA_EQ_cntB. Each tally saturates at all-ones and never wraps.
  - CoutA and CoutB in the same cycle increment both tallies.
  - Window counter decrements every cycle. The cycle in which it is 1 is the last sampled cycle; go to REPORT.
  - Exactly cfg_win cycles are sampled.
- REPORT (1 cycle):
  - done=1; cnt_rst_n=0.
  - verdict registered from the final tallies, valid on the done cycle and held until the next accepted start.
  - Return to IDLE.
- Latency: start accepted at cycle t gives done at t+cfg_win+2. A rejected config gives done at t+1.
- Collisions and guards:
  - start outside IDLE is ignored.
  - start coinciding with done (REPORT) is ignored.
  - Config changes outside IDLE have no effect.
- abort:
  - In LOAD or RUN: next state IDLE, cnt_rst_n=0 immediately the following cycle.
  - No done pulse; tallies and verdict keep their partial/previous values; err unchanged.
  - abort in IDLE or REPORT is ignored.
  - abort and start together in IDLE: start wins.
- rst mid-run: all outputs return to reset values on the next edge; counters held in reset.
- Module outputs hold the last latched values in IDLE after a run (0 only after reset).

Decomposition:
- Package cnt_pair_pkg:
  - typedef enum logic [1:0] state_t {IDLE, LOAD, RUN, REPORT}
  - verdict constants V_EQ, V_A_GT, V_B_GT
  - MOD_W=10
- Sub-module sat_cnt: parameterised saturating incrementer with clear and enable. Three instances, for tallyA, tallyB and eq_hits.

Test Plan:
- Reset then start with modA=4, modB=4, win=40 -> done at start+42; tallyA=10, tallyB=10, eq_hits=40, verdict=00, err=0.
- modA=3, modB=5, win=30 -> tallyA=10, tallyB=6, verdict=01; cnt_rst_n low in the LOAD cycle, high for exactly 30 cycles.
- cfg_modB=0 with start -> done the next cycle, err=1, tallies 0, cnt_rst_n never high.
- abort in the 5th RUN cycle of a win=100 run -> no done; cnt_rst_n=0 the next cycle; busy drops; a second start then runs normally.
- TALLY_W=4, modA=modB=1, win=40 -> tallyA=tallyB=15 (saturated), verdict=00.
- Pulse start during RUN and rst during RUN -> start ignored; after rst all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/cnt_pair_sched_pkg.sv
// Shared types and constants for the two-counter run controller.
package cnt_pair_pkg;

  localparam int MOD_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [1:0] V_EQ   = 2'b00;
  localparam logic [1:0] V_A_GT = 2'b01;
  localparam logic [1:0] V_B_GT = 2'b10;

endpackage

// File: rtl/cnt_pair_sched_if.sv
// Control and counter-side signals of the run controller, bundled as one interface.
interface cnt_pair_sched_if #(
  parameter int WIN_W   = 16,
  parameter int TALLY_W = 12
);
  // Handshake: start is a single-cycle request honoured only while idle (busy=0,
  // done=0); busy stays high through LOAD and RUN, done pulses once per finished
  // or rejected run, and err/verdict/tallies are valid from done onwards.
  logic                            start;
  logic                            abort;
  logic [cnt_pair_pkg::MOD_W-1:0]  cfg_modA;
  logic [cnt_pair_pkg::MOD_W-1:0]  cfg_modB;
  logic [WIN_W-1:0]                cfg_win;
  logic                            CoutA;
  logic                            CoutB;
  logic                            cntA_EQ_cntB;
  logic [cnt_pair_pkg::MOD_W-1:0]  cntA_Module;
  logic [cnt_pair_pkg::MOD_W-1:0]  cntB_Module;
  logic                            cnt_rst_n;
  logic                            busy;
  logic                            done;
  logic                            err;
  logic [TALLY_W-1:0]              tallyA;
  logic [TALLY_W-1:0]              tallyB;
  logic [TALLY_W-1:0]              eq_hits;
  logic [1:0]                      verdict;

  modport master (
    output start, abort, cfg_modA, cfg_modB, cfg_win, CoutA, CoutB, cntA_EQ_cntB,
    input  cntA_Module, cntB_Module, cnt_rst_n, busy, done, err,
           tallyA, tallyB, eq_hits, verdict
  );

  modport slave (
    input  start, abort, cfg_modA, cfg_modB, cfg_win, CoutA, CoutB, cntA_EQ_cntB,
    output cntA_Module, cntB_Module, cnt_rst_n, busy, done, err,
           tallyA, tallyB, eq_hits, verdict
  );

endinterface

// File: rtl/cnt_pair_sched_sat_cnt.sv
// Saturating up-counter with synchronous clear; nxt exposes the value about to be stored.
module sat_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (clr)
      nxt = '0;
    else if (en && (cnt != {W{1'b1}}))
      nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt;
  end

endmodule

// File: rtl/cnt_pair_sched.sv
// Run controller: latches a modulus pair, releases both counters for a window
// of cycles, tallies carries and equality hits, then reports a verdict.
module cnt_pair_sched
  import cnt_pair_pkg::*;
#(
  parameter int WIN_W   = 16,
  parameter int TALLY_W = 12
) (
  input  logic               CLK,
  input  logic               rst,
  cnt_pair_sched_if.slave    bus,
  output state_t             dbg_state
);

  localparam logic [WIN_W-1:0] WIN_ONE = 1;

  state_t             state;
  state_t             state_nxt;
  logic [MOD_W-1:0]   mod_a;
  logic [MOD_W-1:0]   mod_b;
  logic [WIN_W-1:0]   win_cnt;
  logic               err_q;
  logic [1:0]         verdict_q;
  logic               accept;
  logic               bad_cfg;
  logic               abort_hit;
  logic               tally_en;
  logic [TALLY_W-1:0] nxt_a;
  logic [TALLY_W-1:0] nxt_b;
  logic [TALLY_W-1:0] nxt_eq;

  assign accept    = (state == IDLE) && bus.start;
  assign bad_cfg   = (bus.cfg_modA == '0) || (bus.cfg_modB == '0) || (bus.cfg_win == '0);
  assign abort_hit = bus.abort && ((state == LOAD) || (state == RUN));
  assign tally_en  = (state == RUN) && !bus.abort;

  function automatic logic [1:0] calc_verdict(input logic [TALLY_W-1:0] a,
                                              input logic [TALLY_W-1:0] b);
    if (a > b)      return V_A_GT;
    else if (b > a) return V_B_GT;
    else            return V_EQ;
  endfunction

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = bad_cfg ? REPORT : LOAD;
      LOAD:    state_nxt = abort_hit ? IDLE : RUN;
      RUN: begin
        if (abort_hit)              state_nxt = IDLE;
        else if (win_cnt == WIN_ONE) state_nxt = REPORT;
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window length is captured at acceptance; LOAD only holds it while the
  // counters settle on their new modulus.
  always_ff @(posedge CLK) begin
    if (rst) begin
      mod_a     <= '0;
      mod_b     <= '0;
      win_cnt   <= '0;
      err_q     <= 1'b0;
      verdict_q <= V_EQ;
    end else if (accept) begin
      mod_a   <= bus.cfg_modA;
      mod_b   <= bus.cfg_modB;
      win_cnt <= bus.cfg_win;
      err_q   <= bad_cfg;
      if (bad_cfg) verdict_q <= V_EQ;
    end else if (state == RUN) begin
      win_cnt <= win_cnt - 1'b1;
      if ((win_cnt == WIN_ONE) && !bus.abort)
        verdict_q <= calc_verdict(nxt_a, nxt_b);
    end
  end

  sat_cnt #(.W(TALLY_W)) u_tally_a (
    .clk(CLK), .rst(rst), .clr(accept), .en(tally_en && bus.CoutA),
    .cnt(bus.tallyA), .nxt(nxt_a)
  );

  sat_cnt #(.W(TALLY_W)) u_tally_b (
    .clk(CLK), .rst(rst), .clr(accept), .en(tally_en && bus.CoutB),
    .cnt(bus.tallyB), .nxt(nxt_b)
  );

  sat_cnt #(.W(TALLY_W)) u_tally_eq (
    .clk(CLK), .rst(rst), .clr(accept), .en(tally_en && bus.cntA_EQ_cntB),
    .cnt(bus.eq_hits), .nxt(nxt_eq)
  );

  assign bus.cntA_Module = mod_a;
  assign bus.cntB_Module = mod_b;
  assign bus.cnt_rst_n   = (state == RUN);
  assign bus.busy        = (state == LOAD) || (state == RUN);
  assign bus.done        = (state == REPORT);
  assign bus.err         = err_q;
  assign bus.verdict     = verdict_q;
  assign dbg_state       = state;

endmodule
